// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential front end for a combinational 32-bit ALU.
// Accepts one request, decodes ALUOp/funct into a 3-bit ALU code, holds the
// operands on the ALU for the op's hold time (MUL is multi-cycle), captures
// the result and zero flag, and returns them on a valid/ready response port.
module alu_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 3  // legal range 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // request channel
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  aluop_i,
  input  logic [6:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  // ALU interface
  output logic [31:0] alu_data0_o,
  output logic [31:0] alu_data1_o,
  output logic [2:0]  aluctrl_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i,
  // response channel
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_zero_o,
  output logic        rsp_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100
  } alu_code_t;

  localparam logic [3:0] MUL_HOLD   = 4'(MUL_CYCLES);
  localparam logic [3:0] OTHER_HOLD = 4'd1;

  state_t     state;
  logic [3:0] hold_cnt;

  alu_code_t  dec_code;
  logic       dec_valid;

  // Decode the request fields into an ALU code; anything unlisted is invalid.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    dec_valid = 1'b1;
    dec_code  = ALU_ADD;
    case (aluop_i)
      2'b00: dec_code = ALU_ADD;
      2'b01: dec_code = ALU_SUB;
      2'b10: begin
        if      (funct3_i == 3'b000 && funct7_i == 7'b0000000) dec_code = ALU_ADD;
        else if (funct3_i == 3'b000 && funct7_i == 7'b0100000) dec_code = ALU_SUB;
        else if (funct3_i == 3'b000 && funct7_i == 7'b0000001) dec_code = ALU_MUL;
        else if (funct3_i == 3'b111 && funct7_i == 7'b0000000) dec_code = ALU_AND;
        else if (funct3_i == 3'b110 && funct7_i == 7'b0000000) dec_code = ALU_OR;
        else                                                   dec_valid = 1'b0;
      end
      default: begin
        case (funct3_i)
          3'b000:  dec_code = ALU_ADD;
          3'b111:  dec_code = ALU_AND;
          3'b110:  dec_code = ALU_OR;
          default: dec_valid = 1'b0;
        endcase
      end
    endcase
  end

  // Issue FSM with registered handshake, ALU-drive and response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      hold_cnt    <= 4'd0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 32'd0;
      rsp_zero_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
      alu_data0_o <= 32'd0;
      alu_data1_o <= 32'd0;
      aluctrl_o   <= ALU_ADD;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // in this block sees the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            if (dec_valid) begin
              alu_data0_o <= rs1_data_i;
              alu_data1_o <= rs2_data_i;
              aluctrl_o   <= dec_code;
              hold_cnt    <= (dec_code == ALU_MUL) ? MUL_HOLD : OTHER_HOLD;
              state       <= EXEC;
            end else begin
              // Undecodable op: answer at once with an error, ALU untouched.
              rsp_err_o   <= 1'b1;
              rsp_data_o  <= 32'd0;
              rsp_zero_o  <= 1'b0;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end
          end
        end
        EXEC: begin
          hold_cnt <= hold_cnt - 4'd1;
          if (hold_cnt == 4'd1) begin
            rsp_data_o  <= alu_data_i;
            rsp_zero_o  <= alu_zero_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized bench for alu_issue_ctrl, with a
// behavioural ALU on the ALU port and a rule-table reference decoder.
module tb_alu_issue_ctrl;

  localparam int MUL_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  aluop = 2'b00;
  logic [6:0]  funct7 = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [31:0] alu_data0;
  logic [31:0] alu_data1;
  logic [2:0]  aluctrl;
  logic [31:0] alu_data;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  // Operands/code last loaded into the ALU registers (reset gives zeros/ADD).
  logic [31:0] prev_a = 32'd0;
  logic [31:0] prev_b = 32'd0;
  logic [2:0]  prev_code = 3'd0;

  alu_issue_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .aluop_i     (aluop),
    .funct7_i    (funct7),
    .funct3_i    (funct3),
    .rs1_data_i  (rs1),
    .rs2_data_i  (rs2),
    .alu_data0_o (alu_data0),
    .alu_data1_o (alu_data1),
    .aluctrl_o   (aluctrl),
    .alu_data_i  (alu_data),
    .alu_zero_i  (alu_zero),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_zero_o  (rsp_zero),
    .rsp_err_o   (rsp_err)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each ALU code (0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR).
  function automatic logic [31:0] alu_ref(input logic [2:0] code,
                                          input logic [31:0] a, input logic [31:0] b);
    case (code)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  // Environment ALU driven from the DUT's registered ALU inputs.
  always_comb begin
    alu_data = alu_ref(aluctrl, alu_data0, alu_data1);
    alu_zero = (alu_data == 32'd0);
  end

  // Decode rules as a table; -1 means "don't care".
  typedef struct {
    int op;
    int f3;
    int f7;
    int code;
  } rule_t;

  rule_t rules [10] = '{
    '{0, -1,   -1,   0},
    '{1, -1,   -1,   1},
    '{2,  0,   0,    0},
    '{2,  0,   32,   1},
    '{2,  0,   1,    2},
    '{2,  7,   0,    3},
    '{2,  6,   0,    4},
    '{3,  0,   -1,   0},
    '{3,  7,   -1,   3},
    '{3,  6,   -1,   4}
  };

  function automatic void ref_decode(input logic [1:0] op, input logic [6:0] f7,
                                     input logic [2:0] f3, output bit ok,
                                     output logic [2:0] code, output int hold);
    ok = 1'b0; code = 3'd0; hold = 0;
    foreach (rules[i]) begin
      if (!ok && rules[i].op == int'(op) &&
          (rules[i].f3 < 0 || rules[i].f3 == int'(f3)) &&
          (rules[i].f7 < 0 || rules[i].f7 == int'(f7))) begin
        ok   = 1'b1;
        code = 3'(rules[i].code);
        hold = (rules[i].code == 2) ? MUL_CYCLES : 1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".rsp_data"},  rsp_data,       32'd0);
    check({tag, ".rsp_zero"},  32'(rsp_zero),  32'd0);
    check({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, ".data0"},     alu_data0,      32'd0);
    check({tag, ".data1"},     alu_data1,      32'd0);
    check({tag, ".ctrl"},      32'(aluctrl),   32'd0);
  endtask

  // One full transaction, entered and left at a falling edge in IDLE.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output logic [31:0] got_data,
                       output logic got_zero, output logic got_err);
    bit          ok;
    logic [2:0]  code;
    int          hold;
    int          lat;
    logic [31:0] exp_data;
    ref_decode(op, f7, f3, ok, code, hold);
    exp_data = ok ? alu_ref(code, a, b) : 32'd0;

    check({tag, ".ready_T"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; aluop = op; funct7 = f7; funct3 = f3; rs1 = a; rs2 = b;
    @(posedge clk);
    @(negedge clk);
    // Cycle T+1: scramble request fields; they must not be resampled.
    req_valid = 1'($urandom); aluop = 2'($urandom); funct7 = 7'($urandom);
    funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    check({tag, ".ready_T1"}, 32'(req_ready), 32'd0);
    check({tag, ".ctrl_T1"},  32'(aluctrl), ok ? 32'(code) : 32'(prev_code));
    check({tag, ".data0_T1"}, alu_data0, ok ? a : prev_a);
    check({tag, ".data1_T1"}, alu_data1, ok ? b : prev_b);

    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      check({tag, ".ctrl_hold"}, 32'(aluctrl), 32'(code));
      check({tag, ".data0_hold"}, alu_data0, a);
    end
    check({tag, ".latency"},   32'(lat), ok ? 32'(hold + 1) : 32'd1);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rsp_data"},  rsp_data, exp_data);
    check({tag, ".rsp_zero"},  32'(rsp_zero), ok ? 32'(exp_data == 32'd0) : 32'd0);
    check({tag, ".rsp_err"},   32'(rsp_err), ok ? 32'd0 : 32'd1);
    got_data = rsp_data; got_zero = rsp_zero; got_err = rsp_err;

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".stall_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".stall_data"},  rsp_data, exp_data);
      check({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
      check({tag, ".stall_ctrl"},  32'(aluctrl), ok ? 32'(code) : 32'(prev_code));
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(req_ready), 32'd1);
    if (ok) begin
      prev_a = a; prev_b = b; prev_code = code;
    end
  endtask

  logic [31:0] d;
  logic        z;
  logic        e;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_init");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // ADD 5 + 7.
    do_op("add", 2'b10, 7'd0, 3'b000, 32'd5, 32'd7, 0, d, z, e);
    check("add.value", d, 32'd12);
    check("add.zero",  32'(z), 32'd0);

    // SUB with zero result.
    do_op("sub", 2'b01, 7'd0, 3'b000, 32'h1234, 32'h1234, 0, d, z, e);
    check("sub.value", d, 32'd0);
    check("sub.zero",  32'(z), 32'd1);

    // MUL with 5-cycle consumer stall; low 32 bits of 2^32 are zero.
    do_op("mul", 2'b10, 7'b0000001, 3'b000, 32'h10000, 32'h10000, 5, d, z, e);
    check("mul.value", d, 32'd0);
    check("mul.zero",  32'(z), 32'd1);

    // Invalid decode; ALU code must still read MUL from the previous op.
    do_op("inval", 2'b10, 7'd0, 3'b001, 32'hdead, 32'hbeef, 1, d, z, e);
    check("inval.err",  32'(e), 32'd1);
    check("inval.ctrl", 32'(aluctrl), 32'd2);

    // Reset during MUL EXEC at cycle T+2, asserted mid-cycle.
    req_valid = 1'b1; aluop = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000;
    rs1 = 32'd9; rs2 = 32'd11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    prev_a = 32'd0; prev_b = 32'd0; prev_code = 3'd0;
    repeat (4) begin
      @(negedge clk);
      check("reset_mid.no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_op("add_after_rst", 2'b00, 7'd0, 3'b000, 32'd100, 32'hffff_fff0, 0, d, z, e);
    check("add_after_rst.value", d, 32'd84);

    // Randomized ops, biased toward decodable funct fields.
    for (int n = 0; n < 40; n++) begin
      logic [6:0] f7;
      logic [2:0] f3;
      logic [31:0] a;
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: f7 = 7'd0;
        1: f7 = 7'b0100000;
        2: f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: f3 = 3'b000;
        1: f3 = 3'b111;
        2: f3 = 3'b110;
        default: f3 = 3'($urandom);
      endcase
      a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_op("rand", 2'($urandom), f7, f3, a, b, $urandom_range(0, 3), d, z, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Run-length guard against a hung handshake.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation timeout");
  end

endmodule
